// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Fetch state encoding, NOP word and default reset vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    TRAP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bundle.
// The fetcher is master; the memory model is slave.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection for the fetch unit.
// Pure combinational; flags redirect targets with bit 1 set.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        btaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        redirect;

  assign jalr_sum = rs1_data + imm;
  assign redirect = jalr | jal | btaken;

  always_comb begin
    target = pc + imm;
    if (jalr) begin
      target = {jalr_sum[31:1], 1'b0};
    end
  end

  assign next_pc    = redirect ? target : pc + 32'd4;
  assign misaligned = redirect & target[1];

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher.
// Fetches, holds one instruction, then redirects or traps.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err
);

  fetch_state_e state;
  logic [31:0]  npc;
  logic         misaligned;

  next_pc_sel u_sel (
    .pc         (pc),
    .btaken     (btaken),
    .jal        (jal),
    .jalr       (jalr),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .next_pc    (npc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      instr        <= NOP;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            if (misaligned) begin
              state        <= TRAP;
              misalign_err <= 1'b1;
            end else begin
              pc    <= npc;
              state <= FETCH;
            end
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // reset_n gates the request so nothing is issued while held in reset
  assign imem_req    = reset_n & (state == FETCH);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign instr_valid = (state == VALID);

endmodule
